// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-through cache controller:
// address field widths, line geometry and FSM state encoding.
package cache_ctrl_pkg;

  localparam int unsigned OFFSET_W = 2;
  localparam int unsigned INDEX_W  = 3;
  localparam int unsigned TAG_W    = 27;
  localparam int unsigned WORDS    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REFILL,
    ST_WRITE,
    ST_RESPOND
  } state_t;

endpackage

// File: rtl/cache_array.sv
// Data, tag and valid storage for the direct-mapped cache plus the
// combinational hit compare. Only the valid bits are reset.
module cache_array #(
  parameter int unsigned LINES = 8,
  parameter int unsigned WORDS = 4,
  parameter int unsigned IW    = 3,
  parameter int unsigned TW    = 27,
  parameter int unsigned DW    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IW-1:0]       i_index,
  input  logic [TW-1:0]       i_tag,
  input  logic [1:0]          i_offset,
  input  logic                i_fill_we,
  input  logic [1:0]          i_fill_beat,
  input  logic [DW-1:0]       i_fill_data,
  input  logic                i_set_valid,
  input  logic                i_word_we,
  input  logic [DW-1:0]       i_word_data,
  output logic                o_hit,
  output logic [DW-1:0]       o_word
);

  logic [DW-1:0]    r_data [LINES][WORDS];
  logic [TW-1:0]    r_tag  [LINES];
  logic [LINES-1:0] r_valid;

  always_ff @(posedge clk) begin
    if (i_fill_we)   r_data[i_index][i_fill_beat] <= i_fill_data;
    if (i_word_we)   r_data[i_index][i_offset]    <= i_word_data;
    if (i_set_valid) r_tag[i_index]               <= i_tag;
  end

  // A line only becomes valid on its final refill beat, so an interrupted
  // refill never leaves a partially filled line visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             r_valid          <= '0;
    else if (i_set_valid) r_valid[i_index] <= 1'b1;
  end

  assign o_hit  = r_valid[i_index] && (r_tag[i_index] == i_tag);
  assign o_word = r_data[i_index][i_offset];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Refills fetch the whole line from its base word; all outputs are registered.
module cache_ctrl #(
  parameter int unsigned LINES = 8,
  parameter int unsigned WORDS = 4,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_done,
  output logic          cpu_busy,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata
);
  import cache_ctrl_pkg::*;

  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = AW - OFFSET_W - IW;

  state_t              r_state;
  logic [AW-1:0]       r_addr;
  logic [31:0]         r_wdata;
  logic                r_we;
  logic [OFFSET_W-1:0] r_beat;
  logic [31:0]         r_rdata;
  logic                r_done;
  logic                r_busy;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [AW-1:0]       r_mem_addr;
  logic [31:0]         r_mem_wdata;

  logic [IW-1:0]       w_index;
  logic [TW-1:0]       w_tag;
  logic [OFFSET_W-1:0] w_offset;
  logic [OFFSET_W-1:0] w_next_beat;
  logic                w_ack;
  logic                w_hit;
  logic [31:0]         w_word;
  logic                w_fill_we;
  logic                w_set_valid;
  logic                w_word_we;

  assign w_index     = r_addr[OFFSET_W +: IW];
  assign w_tag       = r_addr[AW-1 -: TW];
  assign w_offset    = r_addr[OFFSET_W-1:0];
  assign w_next_beat = r_beat + OFFSET_W'(1);
  assign w_ack       = r_mem_req & mem_ack;
  assign w_fill_we   = (r_state == ST_REFILL) & w_ack;
  assign w_set_valid = w_fill_we & (r_beat == '1);
  assign w_word_we   = (r_state == ST_WRITE) & w_ack & w_hit;

  cache_array #(
    .LINES (LINES),
    .WORDS (WORDS),
    .IW    (IW),
    .TW    (TW),
    .DW    (32)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .i_index     (w_index),
    .i_tag       (w_tag),
    .i_offset    (w_offset),
    .i_fill_we   (w_fill_we),
    .i_fill_beat (r_beat),
    .i_fill_data (mem_rdata),
    .i_set_valid (w_set_valid),
    .i_word_we   (w_word_we),
    .i_word_data (r_wdata),
    .o_hit       (w_hit),
    .o_word      (w_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_beat      <= '0;
      r_rdata     <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cpu_req) begin
            r_addr  <= cpu_addr;
            r_we    <= cpu_we;
            r_wdata <= cpu_wdata;
            r_busy  <= 1'b1;
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (r_we) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= r_wdata;
            r_state     <= ST_WRITE;
          end else if (w_hit) begin
            r_rdata <= w_word;
            r_done  <= 1'b1;
            r_state <= ST_RESPOND;
          end else begin
            r_beat     <= '0;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {w_tag, w_index, OFFSET_W'(0)};
            r_state    <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (w_ack) begin
            r_beat <= w_next_beat;
            if (r_beat == '1) begin
              // The last beat is still on the bus, not yet in the array.
              r_rdata   <= (w_offset == r_beat) ? mem_rdata : w_word;
              r_mem_req <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= ST_RESPOND;
            end else begin
              r_mem_addr <= {w_tag, w_index, w_next_beat};
            end
          end
        end
        ST_WRITE: begin
          if (w_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cpu_rdata = r_rdata;
  assign cpu_done  = r_done;
  assign cpu_busy  = r_busy;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed testbench for cache_ctrl: memory model with configurable stall,
// scoreboard queue of expected memory beats, CPU response checks.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  cache_ctrl #(.LINES(8), .WORDS(4), .AW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_done  (cpu_done),
    .cpu_busy  (cpu_busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  beat_t       exp_beats[$];
  logic [31:0] mem_store [logic [31:0]];
  int          n_total = 0;
  int          n_pass  = 0;
  int          n_done  = 0;
  int          stall   = 0;
  int          st_cnt  = 0;
  int          acks    = 0;
  logic [31:0] hold_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic push_beat(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    beat_t b;
    b.we = we; b.addr = addr; b.wdata = wdata;
    exp_beats.push_back(b);
  endtask

  task automatic push_refill(input logic [31:0] base);
    for (int unsigned i = 0; i < 4; i++) push_beat(1'b0, base + i, '0);
  endtask

  // Memory model: acks after `stall` waiting cycles; reads return stored data or the address.
  always @(negedge clk) begin
    beat_t b;
    if (!rst) begin
      mem_ack = 1'b0;
      st_cnt  = 0;
    end else if (mem_req) begin
      if (st_cnt == 0) hold_addr = mem_addr;
      else chk("stall_addr_stable", mem_addr, hold_addr);
      if (st_cnt >= stall) begin
        mem_ack = 1'b1;
        st_cnt  = 0;
        acks++;
        if (mem_we) mem_store[mem_addr] = mem_wdata;
        else mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : mem_addr;
        if (exp_beats.size() == 0) begin
          chk("beat_expected", exp_beats.size(), 1);
        end else begin
          b = exp_beats.pop_front();
          chk("beat_we", {31'd0, mem_we}, {31'd0, b.we});
          chk("beat_addr", mem_addr, b.addr);
          if (b.we) chk("beat_wdata", mem_wdata, b.wdata);
        end
      end else begin
        mem_ack = 1'b0;
        st_cnt++;
      end
    end else begin
      mem_ack = 1'b0;
      st_cnt  = 0;
    end
  end

  always @(negedge clk) if (rst && cpu_done) n_done++;

  // Latency counts falling edges from the accepting rising edge to cpu_done.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input int exp_lat);
    int cyc = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!cpu_done && cyc < 500);
    chk("done_seen", {31'd0, cpu_done}, 32'd1);
    if (!we) chk("rdata", cpu_rdata, exp_rd);
    chk("latency", cyc, exp_lat);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, cpu_done}, 32'd0);
    chk("busy_after", {31'd0, cpu_busy}, 32'd0);
    chk("beats_outstanding", exp_beats.size(), 0);
  endtask

  initial begin
    int base;
    int t;
    int last;
    int w;

    repeat (2) @(negedge clk);
    chk("rst_done", {31'd0, cpu_done}, 32'd0);
    chk("rst_busy", {31'd0, cpu_busy}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b1;

    // Read miss from line base, then hit in the same line.
    push_refill(32'h4);
    access(1'b0, 32'h6, '0, 32'h6, 6);
    access(1'b0, 32'h5, '0, 32'h5, 2);

    // Write-through hit updates the cached word.
    push_beat(1'b1, 32'h5, 32'hDEADBEEF);
    access(1'b1, 32'h5, 32'hDEADBEEF, '0, 3);
    access(1'b0, 32'h5, '0, 32'hDEADBEEF, 2);

    // Write miss does not allocate; the following read refills from memory.
    push_beat(1'b1, 32'h20, 32'h12345678);
    access(1'b1, 32'h20, 32'h12345678, '0, 3);
    push_refill(32'h20);
    access(1'b0, 32'h20, '0, 32'h12345678, 6);
    access(1'b0, 32'h21, '0, 32'h21, 2);

    // Reset in the middle of a refill.
    push_refill(32'h0);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h3;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    base = acks;
    for (int i = 0; i < 50 && acks < base + 2; i++) @(posedge clk);
    chk("reset_two_acks_seen", acks - base, 2);
    #2 rst = 1'b0;
    #1;
    chk("reset_mem_req_drop", {31'd0, mem_req}, 32'd0);
    chk("reset_busy_drop", {31'd0, cpu_busy}, 32'd0);
    exp_beats.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push_refill(32'h0);
    access(1'b0, 32'h3, '0, 32'h3, 6);

    // cpu_req held high with a stalled memory: one access per cpu_done.
    stall = 5;
    push_refill(32'h40);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h41;
    t = 0;
    last = 0;
    for (int k = 0; k < 3; k++) begin
      w = 0;
      do begin
        @(negedge clk);
        t++;
        w++;
      end while (!cpu_done && w < 400);
      chk("cont_done", {31'd0, cpu_done}, 32'd1);
      chk("cont_rdata", cpu_rdata, 32'h41);
      if (k > 0) chk("cont_spacing", t - last, 3);
      last = t;
    end
    cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("cont_busy_end", {31'd0, cpu_busy}, 32'd0);
    chk("cont_beats_outstanding", exp_beats.size(), 0);
    stall = 0;

    repeat (3) @(negedge clk);
    chk("done_total", n_done, 11);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 The block SHALL expose these parameters: LINES, 8, number of cache lines; WORDS, 4, words per line (fixed); AW, 32, word-address width.
REQ-002 Port list SHALL be: clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset, asynchronous, active-low; state clears while 0.
REQ-004 cpu_req  in  1  CPU access request, sampled only in IDLE.
REQ-005 cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req.
REQ-006 cpu_addr  in  32  word address: [1:0] offset, [4:2] index, [31:5] tag.
REQ-007 cpu_wdata  in  32  write data.
REQ-008 cpu_rdata  out  32  read data, valid while cpu_done=1.
REQ-009 cpu_done  out  1  one-cycle completion pulse.
REQ-010 cpu_busy  out  1  1 in any state other than IDLE.
REQ-011 mem_req  out  1  memory request, held until the matching mem_ack.
REQ-012 mem_we  out  1  1 = write-through beat, 0 = refill beat.
REQ-013 mem_addr  out  32  word address for the current beat.
REQ-014 mem_wdata  out  32  write-through data.
REQ-015 mem_ack  in  1  beat accepted; for reads, mem_rdata is valid in the same cycle.
REQ-016 mem_rdata  in  32  refill word.

Function
REQ-017 The cache SHALL be direct-mapped, LINES x 4 words, with per-line valid bits and 27-bit tags, write-through and no write-allocate.
REQ-018 The FSM SHALL have states IDLE, LOOKUP, REFILL, WRITE and RESPOND, and all outputs SHALL be registered.
REQ-019 IDLE: when cpu_req=1, the block SHALL latch addr, we and wdata, then go to LOOKUP; otherwise it SHALL stay in IDLE.
REQ-020 LOOKUP read hit (valid[index] and tag match): the block SHALL load cpu_rdata with the addressed word and go to RESPOND, so cpu_done rises 2 cycles after acceptance.
REQ-021 LOOKUP read miss: the block SHALL clear beat to 0 and go to REFILL.
REQ-022 LOOKUP write, hit or miss: the block SHALL go to WRITE.
REQ-023 REFILL: mem_req=1, mem_we=0, and mem_addr={tag,index,beat}, starting at the line base (offset 0), not at the requested word.
REQ-024 On each mem_ack in REFILL, the block SHALL store mem_rdata into word[beat] and increment beat; the 2-bit beat counter SHALL wrap 3->0.
REQ-025 On the mem_ack of beat 3, the block SHALL set valid[index], write the tag, load cpu_rdata with the requested word, and go to RESPOND.
REQ-026 WRITE: mem_req=1, mem_we=1, mem_addr=latched addr, mem_wdata=latched wdata.
REQ-027 On mem_ack in WRITE, the block SHALL update the cached word if the access hit, leave the line untouched on a miss, and go to RESPOND.
REQ-028 RESPOND: the block SHALL pulse cpu_done for one cycle and return to IDLE; a new cpu_req is accepted no earlier than the following cycle.
REQ-029 The block SHALL ignore cpu_req while cpu_busy=1 and SHALL ignore mem_ack while mem_req=0.
REQ-030 mem_req SHALL drop in the cycle after the final ack; there SHALL be no idle gap between refill beats.

Reset
REQ-031 With rst=0, the block SHALL set state=IDLE, all valid bits=0, beat=0, mem_req=0, mem_we=0, cpu_done=0, cpu_busy=0, cpu_rdata=0, mem_addr=0 and mem_wdata=0.
REQ-032 Reset during a refill SHALL abandon the partial line, leaving it invalid, and SHALL drop mem_req asynchronously.
REQ-033 Data and tag arrays need no reset.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the field widths (OFFSET_W=2, INDEX_W=3, TAG_W=27) and WORDS=4.
REQ-035 One sub-module, cache_array, SHALL hold the data, tag and valid storage and perform the combinational hit compare; the FSM SHALL stay in cache_ctrl.

Verification
REQ-036 After reset, read 0x00000006 with the memory model returning data=addr -> mem_addr 0x4,0x5,0x6,0x7 in order; cpu_rdata=0x6; one cpu_done pulse.
REQ-037 Immediately re-read 0x00000005 -> no mem_req; cpu_done exactly 2 cycles after acceptance; cpu_rdata=0x5.
REQ-038 Write 0x00000005 with 0xDEADBEEF, then read 0x00000005 -> one mem_we=1 beat to 0x5; the read hits and returns 0xDEADBEEF.
REQ-039 Write to uncached 0x00000020, then read 0x00000020 -> the write does not allocate; the read then triggers a 4-beat refill from 0x20.
REQ-040 Assert rst=0 after the 2nd refill ack, then re-read the same address -> mem_req drops immediately; the re-read performs a full 4-beat refill.
REQ-041 Drive cpu_req=1 continuously with mem_ack stalled 5 cycles per beat -> exactly one access per cpu_done, no request accepted while busy, mem_addr stable while stalled.
